// File: rtl/out_wb_engine_pkg.sv
// -----------------------------------------------------------------------------
// out_wb_engine_pkg
//
// Shared definitions for the output write-back engine:
//   - wb_state_e : job state encoding (IDLE, RUN, DONE)
//   - DESIGN_SIZE, DEF_DWIDTH, DEF_AWIDTH, DEF_DEPTH : default geometry that
//     matches the surrounding accelerator (lanes per row, bits per lane,
//     activation BRAM address width, write-back FIFO depth).
// -----------------------------------------------------------------------------
package out_wb_engine_pkg;

    // Default geometry of the activation/output path.
    localparam int DESIGN_SIZE     = 4;
    localparam int DEF_DWIDTH      = 8;
    localparam int DEF_AWIDTH      = 10;
    localparam int DEF_DEPTH       = 4;
    localparam int DEF_CNT_WIDTH   = 16;
    localparam int DEF_STRIDE_WIDTH = 16;

    // Job state of the write-back engine.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } wb_state_e;

endpackage : out_wb_engine_pkg

// File: rtl/out_wb_engine_wb_fifo.sv
// -----------------------------------------------------------------------------
// out_wb_engine_wb_fifo
//
// Synchronous FIFO buffering accepted rows until the shared BRAM port is
// granted. The head entry is presented combinationally on pop_data.
//
// Parameters:
//   WIDTH  bits per entry
//   DEPTH  number of entries (power of two, at least 2)
//
// Ports:
//   clk        in   sole clock
//   reset      in   asynchronous, active-high; empties the FIFO
//   push       in   write push_data at the tail
//   push_data  in   WIDTH  entry to write
//   pop        in   remove the head entry
//   pop_data   out  WIDTH  current head entry
//   full       out  no free entry
//   empty      out  no valid entry
// -----------------------------------------------------------------------------
module out_wb_engine_wb_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so that full and empty can be told
    // apart when the index bits are equal.
    logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic               do_push;
    logic               do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop_data = mem_q[rd_ptr_q[PTR_W-1:0]];

    // A push into a full FIFO is only legal when the head leaves in the same
    // cycle; the slot being refilled is the one just read out.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    // Next-pointer computation.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        end
    end

    // Pointer registers; reset discards every stored entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
        end
    end

endmodule : out_wb_engine_wb_fifo

// File: rtl/out_wb_engine.sv
// -----------------------------------------------------------------------------
// out_wb_engine
//
// Output write-back engine between the last post-processing stage and the
// write port of the activation/output BRAM. Rows arrive over a valid/ready
// handshake, are buffered in a FIFO, and are written to the BRAM through a
// request/grant handshake at addresses generated with a signed per-row stride.
// A job is started by a one-cycle start pulse and ends after num_rows writes
// with a one-cycle done pulse.
//
// Configuration macro:
//   OUT_WB_LANE_MASK_EN  defined   : bram_we = lane_mask latched at start
//                        undefined : bram_we = all ones, lane_mask ignored
//
// Ports:
//   clk          in   sole clock
//   reset        in   asynchronous, active-high; aborts any job
//   start        in   one-cycle pulse latching the job parameters
//   base_addr    in   AWIDTH        address of the first row
//   addr_stride  in   STRIDE_WIDTH  signed per-row address increment
//   num_rows     in   CNT_WIDTH     rows in the job
//   lane_mask    in   LANES         per-lane write mask
//   in_valid     in   input row valid
//   in_data      in   LANES*DWIDTH  input row, lane 0 in the LSBs
//   in_ready     out  row accepted when in_valid is also high
//   bram_req     out  request for the BRAM write port
//   bram_gnt     in   port granted this cycle
//   bram_addr    out  AWIDTH        write address
//   bram_wdata   out  LANES*DWIDTH  write data
//   bram_we      out  LANES         per-lane write enable
//   busy         out  job active (RUN or DONE)
//   done         out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module out_wb_engine
    import out_wb_engine_pkg::*;
#(
    parameter int LANES        = DESIGN_SIZE,
    parameter int DWIDTH       = DEF_DWIDTH,
    parameter int AWIDTH       = DEF_AWIDTH,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
    parameter int STRIDE_WIDTH = DEF_STRIDE_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [AWIDTH-1:0]         base_addr,
    input  logic [STRIDE_WIDTH-1:0]   addr_stride,
    input  logic [CNT_WIDTH-1:0]      num_rows,
    input  logic [LANES-1:0]          lane_mask,
    input  logic                      in_valid,
    input  logic [LANES*DWIDTH-1:0]   in_data,
    output logic                      in_ready,
    output logic                      bram_req,
    input  logic                      bram_gnt,
    output logic [AWIDTH-1:0]         bram_addr,
    output logic [LANES*DWIDTH-1:0]   bram_wdata,
    output logic [LANES-1:0]          bram_we,
    output logic                      busy,
    output logic                      done
);

    localparam int ROW_W = LANES * DWIDTH;
    localparam int EXT_W = (AWIDTH > STRIDE_WIDTH) ? AWIDTH : STRIDE_WIDTH;

    wb_state_e                  state_q, state_d;
    logic [AWIDTH-1:0]          cur_addr_q, cur_addr_d;
    logic [STRIDE_WIDTH-1:0]    addr_stride_q, addr_stride_d;
    logic [CNT_WIDTH-1:0]       num_rows_q, num_rows_d;
    logic [CNT_WIDTH-1:0]       acc_cnt_q, acc_cnt_d;
    logic [CNT_WIDTH-1:0]       wr_cnt_q, wr_cnt_d;
    logic [LANES-1:0]           lane_mask_q, lane_mask_d;
    logic [AWIDTH-1:0]          bram_addr_q, bram_addr_d;
    logic [ROW_W-1:0]           bram_wdata_q, bram_wdata_d;
    logic [LANES-1:0]           bram_we_q, bram_we_d;

    logic                       fifo_full;
    logic                       fifo_empty;
    logic [ROW_W-1:0]           fifo_head;
    logic                       push;
    logic                       pop;
    logic [LANES-1:0]           lane_mask_in;
    logic [EXT_W-1:0]           stride_ext;
    logic [AWIDTH-1:0]          addr_step;
    logic [CNT_WIDTH-1:0]       wr_cnt_inc;

`ifdef OUT_WB_LANE_MASK_EN
    assign lane_mask_in = lane_mask;
`else
    // Without per-lane masking every write covers the whole row.
    logic unused_lane_mask;
    assign unused_lane_mask = ^lane_mask;
    assign lane_mask_in     = '1;
`endif

    // The stride is sign-extended before being cut to the address width so
    // that negative strides walk downwards and all arithmetic wraps mod 2^AWIDTH.
    assign stride_ext = EXT_W'($signed(addr_stride_q));
    assign addr_step  = stride_ext[AWIDTH-1:0];
    assign wr_cnt_inc = wr_cnt_q + CNT_WIDTH'(1);

    assign in_ready = (state_q == ST_RUN) && !fifo_full && (acc_cnt_q < num_rows_q);
    assign bram_req = (state_q == ST_RUN) && !fifo_empty;
    assign push     = in_valid && in_ready;
    assign pop      = bram_req && bram_gnt;

    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign bram_addr  = bram_addr_q;
    assign bram_wdata = bram_wdata_q;
    assign bram_we    = bram_we_q;

    // Row buffer between the input handshake and the BRAM port.
    out_wb_engine_wb_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (DEPTH)
    ) u_wb_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Job control: state transitions, parameter latching, counters, address
    // generation and the registered BRAM write port. Write enables default to
    // zero so a write happens only in the cycle following a granted pop, while
    // address and data keep their last values.
    always_comb begin
        state_d       = state_q;
        cur_addr_d    = cur_addr_q;
        addr_stride_d = addr_stride_q;
        num_rows_d    = num_rows_q;
        acc_cnt_d     = acc_cnt_q;
        wr_cnt_d      = wr_cnt_q;
        lane_mask_d   = lane_mask_q;
        bram_addr_d   = bram_addr_q;
        bram_wdata_d  = bram_wdata_q;
        bram_we_d     = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cur_addr_d    = base_addr;
                    addr_stride_d = addr_stride;
                    num_rows_d    = num_rows;
                    lane_mask_d   = lane_mask_in;
                    acc_cnt_d     = '0;
                    wr_cnt_d      = '0;
                    state_d       = (num_rows == '0) ? ST_DONE : ST_RUN;
                end
            end

            ST_RUN: begin
                if (push) begin
                    acc_cnt_d = acc_cnt_q + CNT_WIDTH'(1);
                end
                if (pop) begin
                    bram_addr_d  = cur_addr_q;
                    bram_wdata_d = fifo_head;
                    bram_we_d    = lane_mask_q;
                    cur_addr_d   = cur_addr_q + addr_step;
                    wr_cnt_d     = wr_cnt_inc;
                    // DONE is entered together with the final write so that
                    // done coincides with the last bram_we.
                    if (wr_cnt_inc == num_rows_q) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any job in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cur_addr_q    <= '0;
            addr_stride_q <= '0;
            num_rows_q    <= '0;
            acc_cnt_q     <= '0;
            wr_cnt_q      <= '0;
            lane_mask_q   <= '0;
            bram_addr_q   <= '0;
            bram_wdata_q  <= '0;
            bram_we_q     <= '0;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            addr_stride_q <= addr_stride_d;
            num_rows_q    <= num_rows_d;
            acc_cnt_q     <= acc_cnt_d;
            wr_cnt_q      <= wr_cnt_d;
            lane_mask_q   <= lane_mask_d;
            bram_addr_q   <= bram_addr_d;
            bram_wdata_q  <= bram_wdata_d;
            bram_we_q     <= bram_we_d;
        end
    end

endmodule : out_wb_engine

// File: tb/tb_out_wb_engine.sv
// -----------------------------------------------------------------------------
// tb_out_wb_engine
//
// Directed bench for out_wb_engine with default geometry (4 lanes x 8 bits,
// 10-bit addresses, 4-entry FIFO). Expected BRAM writes are queued when a row
// is accepted and matched against the writes the DUT actually performs.
// -----------------------------------------------------------------------------
module tb_out_wb_engine;

    localparam int LANES        = 4;
    localparam int DWIDTH       = 8;
    localparam int AWIDTH       = 10;
    localparam int DEPTH        = 4;
    localparam int CNT_WIDTH    = 16;
    localparam int STRIDE_WIDTH = 16;
    localparam int ROW_W        = LANES * DWIDTH;

    typedef struct {
        logic [AWIDTH-1:0] addr;
        logic [ROW_W-1:0]  data;
        logic [LANES-1:0]  we;
    } exp_t;

    typedef struct {
        logic [AWIDTH-1:0] addr;
        logic [ROW_W-1:0]  data;
        logic [LANES-1:0]  we;
        int                cyc;
    } obs_t;

    logic                    clk;
    logic                    reset;
    logic                    start;
    logic [AWIDTH-1:0]       base_addr;
    logic [STRIDE_WIDTH-1:0] addr_stride;
    logic [CNT_WIDTH-1:0]    num_rows;
    logic [LANES-1:0]        lane_mask;
    logic                    in_valid;
    logic [ROW_W-1:0]        in_data;
    logic                    in_ready;
    logic                    bram_req;
    logic                    bram_gnt;
    logic [AWIDTH-1:0]       bram_addr;
    logic [ROW_W-1:0]        bram_wdata;
    logic [LANES-1:0]        bram_we;
    logic                    busy;
    logic                    done;

    exp_t                    sb[$];
    obs_t                    obs_q[$];
    int                      obs_idx;
    int                      cycle_cnt;
    int                      checks;
    int                      failures;
    int                      last_accept_cyc;

    logic [AWIDTH-1:0]       exp_addr;
    logic [STRIDE_WIDTH-1:0] exp_stride;
    logic [LANES-1:0]        exp_we;

    out_wb_engine #(
        .LANES        (LANES),
        .DWIDTH       (DWIDTH),
        .AWIDTH       (AWIDTH),
        .DEPTH        (DEPTH),
        .CNT_WIDTH    (CNT_WIDTH),
        .STRIDE_WIDTH (STRIDE_WIDTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .addr_stride (addr_stride),
        .num_rows    (num_rows),
        .lane_mask   (lane_mask),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .bram_req    (bram_req),
        .bram_gnt    (bram_gnt),
        .bram_addr   (bram_addr),
        .bram_wdata  (bram_wdata),
        .bram_we     (bram_we),
        .busy        (busy),
        .done        (done)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running cycle counter used to time-stamp observed writes.
    initial cycle_cnt = 0;
    always @(posedge clk) begin
        cycle_cnt <= cycle_cnt + 1;
    end

    // Write monitor: records every BRAM write away from the active edge.
    always @(negedge clk) begin
        if (!reset && bram_we != '0) begin
            obs_q.push_back('{bram_addr, bram_wdata, bram_we, cycle_cnt});
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=time_limit required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counted, and reported on mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Offer one row; on acceptance queue the write it must produce.
    task automatic applyStimulus(input logic [ROW_W-1:0] data, input int budget,
                                 output bit accepted);
        int waited;
        accepted = 1'b0;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = data;
        while (!accepted && waited < budget) begin
            @(negedge clk);
            if (in_ready) begin
                accepted        = 1'b1;
                last_accept_cyc = cycle_cnt;
                sb.push_back('{exp_addr, data, exp_we});
                exp_addr = exp_addr + exp_stride[AWIDTH-1:0];
                @(posedge clk);
                #1;
            end else begin
                waited++;
            end
        end
        if (!accepted) begin
            in_valid = 1'b0;
        end
    endtask

    // Pulse start for one cycle; the model follows only when asked to.
    task automatic pulseStart(input logic [AWIDTH-1:0] base, input logic [STRIDE_WIDTH-1:0] stride,
                              input logic [CNT_WIDTH-1:0] rows, input logic [LANES-1:0] mask,
                              input bit update_model);
        @(posedge clk);
        #1;
        start       = 1'b1;
        base_addr   = base;
        addr_stride = stride;
        num_rows    = rows;
        lane_mask   = mask;
        if (update_model) begin
            exp_addr   = base;
            exp_stride = stride;
`ifdef OUT_WB_LANE_MASK_EN
            exp_we     = mask;
`else
            exp_we     = '1;
`endif
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Wait (bounded) for done, leaving the bench in the done cycle.
    task automatic waitDone(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        #1;
        while (!done && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!done) begin
            checkOutput({tag, "_done_timeout"}, done, 1);
        end
    endtask

    // Match queued expectations against recorded writes, in order.
    task automatic compareWrites(input string tag);
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (obs_idx < obs_q.size()) begin
                checkOutput({tag, "_addr"}, obs_q[obs_idx].addr, e.addr);
                checkOutput({tag, "_data"}, obs_q[obs_idx].data, e.data);
                checkOutput({tag, "_we"},   obs_q[obs_idx].we,   e.we);
                obs_idx++;
            end else begin
                checkOutput({tag, "_missing_write"}, obs_q.size(), obs_idx + 1);
            end
        end
        checkOutput({tag, "_extra_write"}, obs_q.size(), obs_idx);
        obs_idx = obs_q.size();
    endtask

    // Directed test sequence.
    initial begin
        bit acc;
        int base;
        int n_acc;
        int i;

        checks          = 0;
        failures        = 0;
        obs_idx         = 0;
        last_accept_cyc = 0;
        exp_addr        = '0;
        exp_stride      = '0;
        exp_we          = '0;
        reset           = 1'b1;
        start           = 1'b0;
        base_addr       = '0;
        addr_stride     = '0;
        num_rows        = '0;
        lane_mask       = '0;
        in_valid        = 1'b0;
        in_data         = '0;
        bram_gnt        = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready",   in_ready,   0);
        checkOutput("rst_bram_req",   bram_req,   0);
        checkOutput("rst_bram_addr",  bram_addr,  0);
        checkOutput("rst_bram_wdata", bram_wdata, 0);
        checkOutput("rst_bram_we",    bram_we,    0);
        checkOutput("rst_busy",       busy,       0);
        checkOutput("rst_done",       done,       0);
        reset = 1'b0;

        // Descending writes, back-to-back rows, 5th row never accepted.
        $display("[TB] test 1: 4 rows, base 0x20, stride -1");
        bram_gnt = 1'b1;
        pulseStart(10'h020, 16'hFFFF, 4, 4'b0101, 1'b1);
        base = obs_q.size();
        applyStimulus(32'h11223344, 5, acc);
        i = last_accept_cyc;
        applyStimulus(32'h55667788, 5, acc);
        applyStimulus(32'h99AABBCC, 5, acc);
        applyStimulus(32'hDDEEFF00, 5, acc);
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        @(negedge clk);
        #1;
        checkOutput("t1_fifth_row_ready", in_ready, 0);
        waitDone("t1");
        checkOutput("t1_done_with_last_we", bram_we, exp_we);
        checkOutput("t1_busy_at_done", busy, 1);
        checkOutput("t1_write_count", obs_q.size() - base, 4);
        if (obs_q.size() - base >= 4) begin
            checkOutput("t1_first_write_latency", obs_q[base].cyc - i, 2);
            checkOutput("t1_consecutive_writes", obs_q[base+3].cyc - obs_q[base].cyc, 3);
        end
        @(negedge clk);
        #1;
        checkOutput("t1_busy_fall", busy, 0);
        checkOutput("t1_done_fall", done, 0);
        in_valid = 1'b0;
        compareWrites("t1");

        // Address wrap-around with a positive stride.
        $display("[TB] test 2: 3 rows, base 0x3F0, stride +16");
        pulseStart(10'h3F0, 16'd16, 3, 4'b0101, 1'b1);
        base = obs_q.size();
        applyStimulus(32'hA1A2A3A4, 5, acc);
        applyStimulus(32'hB1B2B3B4, 5, acc);
        applyStimulus(32'hC1C2C3C4, 5, acc);
        in_valid = 1'b0;
        waitDone("t2");
        checkOutput("t2_write_count", obs_q.size() - base, 3);
        if (obs_q.size() - base >= 3) begin
            checkOutput("t2_wrap_addr1", obs_q[base+1].addr, 10'h000);
            checkOutput("t2_wrap_addr2", obs_q[base+2].addr, 10'h010);
        end
        compareWrites("t2");

        // Grant withheld: FIFO fills, then drains in order.
        $display("[TB] test 3: 6 rows with grant held low");
        bram_gnt = 1'b0;
        pulseStart(10'h100, 16'd1, 6, 4'b0101, 1'b1);
        base  = obs_q.size();
        n_acc = 0;
        for (int r = 0; r < 6; r++) begin
            applyStimulus(32'hA0A00000 + r, 3, acc);
            if (acc) n_acc++;
        end
        in_valid = 1'b0;
        checkOutput("t3_accepted_while_stalled", n_acc, DEPTH);
        @(negedge clk);
        #1;
        checkOutput("t3_in_ready_full", in_ready, 0);
        checkOutput("t3_req_while_stalled", bram_req, 1);
        checkOutput("t3_no_write_while_stalled", obs_q.size() - base, 0);
        bram_gnt = 1'b1;
        for (int r = n_acc; r < 6; r++) begin
            applyStimulus(32'hA0A00000 + r, 10, acc);
        end
        in_valid = 1'b0;
        waitDone("t3");
        checkOutput("t3_write_count", obs_q.size() - base, 6);
        compareWrites("t3");

        // Zero-row job: immediate done, no request.
        $display("[TB] test 4: num_rows = 0");
        base = obs_q.size();
        pulseStart(10'h055, 16'd1, 0, 4'b0101, 1'b1);
        @(negedge clk);
        #1;
        checkOutput("t4_done", done, 1);
        checkOutput("t4_busy", busy, 1);
        checkOutput("t4_no_req", bram_req, 0);
        @(negedge clk);
        #1;
        checkOutput("t4_done_fall", done, 0);
        checkOutput("t4_busy_fall", busy, 0);
        checkOutput("t4_no_req_after", bram_req, 0);
        checkOutput("t4_no_write", obs_q.size() - base, 0);

        // Start while busy is ignored.
        $display("[TB] test 5: start during RUN");
        bram_gnt = 1'b0;
        pulseStart(10'h050, 16'd2, 2, 4'b0101, 1'b1);
        base = obs_q.size();
        applyStimulus(32'h0BADF00D, 5, acc);
        in_valid = 1'b0;
        pulseStart(10'h200, 16'd5, 7, 4'b1111, 1'b0);
        checkOutput("t5_busy_after_restart", busy, 1);
        applyStimulus(32'hCAFEF00D, 5, acc);
        in_valid = 1'b0;
        bram_gnt = 1'b1;
        waitDone("t5");
        checkOutput("t5_write_count", obs_q.size() - base, 2);
        compareWrites("t5");

        // Asynchronous reset with rows pending, then a fresh job.
        $display("[TB] test 6: reset mid-job");
        bram_gnt = 1'b0;
        pulseStart(10'h010, 16'd1, 4, 4'b0101, 1'b1);
        applyStimulus(32'h12121212, 5, acc);
        applyStimulus(32'h34343434, 5, acc);
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t6_in_ready",   in_ready,   0);
        checkOutput("t6_bram_req",   bram_req,   0);
        checkOutput("t6_bram_addr",  bram_addr,  0);
        checkOutput("t6_bram_wdata", bram_wdata, 0);
        checkOutput("t6_bram_we",    bram_we,    0);
        checkOutput("t6_busy",       busy,       0);
        checkOutput("t6_done",       done,       0);
        sb.delete();
        obs_idx  = obs_q.size();
        base     = obs_q.size();
        bram_gnt = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("t6_done_in_reset", done, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("t6_no_write_after_abort", obs_q.size() - base, 0);
        checkOutput("t6_no_req_after_abort", bram_req, 0);
        pulseStart(10'h030, 16'd3, 2, 4'b0101, 1'b1);
        applyStimulus(32'h56565656, 5, acc);
        applyStimulus(32'h78787878, 5, acc);
        in_valid = 1'b0;
        waitDone("t6");
        checkOutput("t6_write_count", obs_q.size() - base, 2);
        compareWrites("t6");

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_out_wb_engine
